// File: rtl/fcnn_infer_ctrl.sv
// rtl/fcnn_infer_ctrl.sv - inference sequencer for the 121-input, 10-class fully connected classifier
//
// Purpose:
//   Accepts one binarised image, holds it on feat_out, then scans every output neuron.
//   Each class index is held on neuron_sel for NEURON_LAT cycles. The class score is
//   sampled on the last cycle of that window. A running argmax is kept, and the winning
//   class is returned over a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   img_vld      image offered                   img_rdy      controller can accept an image
//   img_data     image bits                      feat_out     captured image (input feature register)
//   neuron_en    datapath evaluate enable        neuron_sel   class index under evaluation
//   score_in     signed class score              busy         inference in progress
//   res_vld      result valid                    res_rdy      result consumed
//   res_digit    argmax class                    res_score    score of the argmax class
//   infer_cycles (FCNN_INFER_PERF_CNT_EN only) cycles spent busy on the last pass, saturating
//
// Optional feature macro: FCNN_INFER_PERF_CNT_EN adds the infer_cycles port and its counter.

module fcnn_infer_ctrl #(
  parameter int IMAGE_SIZE  = 121,
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  parameter int NEURON_LAT  = 2,
  parameter int IDX_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  img_vld,
  output logic                  img_rdy,
  input  logic [IMAGE_SIZE-1:0] img_data,
  output logic [IMAGE_SIZE-1:0] feat_out,
  output logic                  neuron_en,
  output logic [IDX_W-1:0]      neuron_sel,
  input  logic [SCORE_W-1:0]    score_in,
  output logic                  busy,
  output logic                  res_vld,
  input  logic                  res_rdy,
  output logic [IDX_W-1:0]      res_digit,
  output logic [SCORE_W-1:0]    res_score
`ifdef FCNN_INFER_PERF_CNT_EN
  ,
  output logic [15:0]           infer_cycles
`endif
);

  localparam int PH_W = (NEURON_LAT > 1) ? $clog2(NEURON_LAT) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(NEURON_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_n;

  logic                  r_img_rdy,  w_img_rdy_n;
  logic [IMAGE_SIZE-1:0] r_feat;
  logic                  r_en,       w_en_n;
  logic [IDX_W-1:0]      r_sel,      w_sel_n;
  logic [PH_W-1:0]       r_phase,    w_phase_n;
  logic                  r_busy,     w_busy_n;
  logic                  r_res_vld,  w_res_vld_n;
  logic [IDX_W-1:0]      r_digit,    w_digit_n;
  logic [SCORE_W-1:0]    r_rscore,   w_rscore_n;
  logic [SCORE_W-1:0]    r_best_score, w_best_score_n;
  logic [IDX_W-1:0]      r_best_idx,   w_best_idx_n;

  logic                  w_capture;
  logic                  w_take;
  logic [SCORE_W-1:0]    w_cand_score;
  logic [IDX_W-1:0]      w_cand_idx;

  // Index 0 always seeds the best; later indices must be strictly greater so ties keep the lower index.
  assign w_take       = (r_sel == '0) || ($signed(score_in) > $signed(r_best_score));
  assign w_cand_score = w_take ? score_in : r_best_score;
  assign w_cand_idx   = w_take ? r_sel    : r_best_idx;

  always_comb begin
    w_state_n      = r_state;
    w_img_rdy_n    = r_img_rdy;
    w_en_n         = r_en;
    w_sel_n        = r_sel;
    w_phase_n      = r_phase;
    w_busy_n       = r_busy;
    w_res_vld_n    = r_res_vld;
    w_digit_n      = r_digit;
    w_rscore_n     = r_rscore;
    w_best_score_n = r_best_score;
    w_best_idx_n   = r_best_idx;
    w_capture      = 1'b0;

    case (r_state)
      IDLE: begin
        w_img_rdy_n = 1'b1;
        w_busy_n    = 1'b0;
        w_en_n      = 1'b0;
        w_res_vld_n = 1'b0;
        // r_img_rdy is 0 on the first cycle out of reset, so no capture can happen there.
        if (img_vld && r_img_rdy) begin
          w_capture   = 1'b1;
          w_img_rdy_n = 1'b0;
          w_busy_n    = 1'b1;
          w_state_n   = LOAD;
        end
      end

      LOAD: begin
        w_busy_n  = 1'b1;
        w_en_n    = 1'b1;
        w_sel_n   = '0;
        w_phase_n = '0;
        w_state_n = COMPUTE;
      end

      COMPUTE: begin
        w_busy_n = 1'b1;
        if (r_phase == PH_LAST) begin
          w_best_score_n = w_cand_score;
          w_best_idx_n   = w_cand_idx;
          if (r_sel == IDX_LAST) begin
            w_en_n      = 1'b0;
            w_res_vld_n = 1'b1;
            w_digit_n   = w_cand_idx;
            w_rscore_n  = w_cand_score;
            w_state_n   = DONE;
          end else begin
            w_sel_n   = r_sel + 1'b1;
            w_phase_n = '0;
          end
        end else begin
          w_phase_n = r_phase + 1'b1;
        end
      end

      DONE: begin
        w_busy_n = 1'b1;
        if (r_res_vld && res_rdy) begin
          w_res_vld_n = 1'b0;
          w_busy_n    = 1'b0;
          w_img_rdy_n = 1'b1;
          w_state_n   = IDLE;
        end
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_img_rdy    <= 1'b0;
      r_feat       <= '0;
      r_en         <= 1'b0;
      r_sel        <= '0;
      r_phase      <= '0;
      r_busy       <= 1'b0;
      r_res_vld    <= 1'b0;
      r_digit      <= '0;
      r_rscore     <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
    end else begin
      r_state      <= w_state_n;
      r_img_rdy    <= w_img_rdy_n;
      r_en         <= w_en_n;
      r_sel        <= w_sel_n;
      r_phase      <= w_phase_n;
      r_busy       <= w_busy_n;
      r_res_vld    <= w_res_vld_n;
      r_digit      <= w_digit_n;
      r_rscore     <= w_rscore_n;
      r_best_score <= w_best_score_n;
      r_best_idx   <= w_best_idx_n;
      if (w_capture) begin
        r_feat <= img_data;
      end
    end
  end

`ifdef FCNN_INFER_PERF_CNT_EN
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_n;
  logic [15:0] r_infer;

  // Counts LOAD and COMPUTE cycles. The value latched on entry to DONE includes the entry cycle itself.
  assign w_cnt_n = (r_busy && !r_res_vld && (r_cnt != 16'hFFFF)) ? (r_cnt + 16'd1) : r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_infer <= '0;
    end else begin
      if (w_capture) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_n;
      end
      if (w_res_vld_n && !r_res_vld) begin
        r_infer <= w_cnt_n;
      end
    end
  end

  assign infer_cycles = r_infer;
`endif

  assign img_rdy    = r_img_rdy;
  assign feat_out   = r_feat;
  assign neuron_en  = r_en;
  assign neuron_sel = r_sel;
  assign busy       = r_busy;
  assign res_vld    = r_res_vld;
  assign res_digit  = r_digit;
  assign res_score  = r_rscore;

endmodule

// File: doc/fcnn_infer_ctrl.md
Name: fcnn_infer_ctrl

Overview:
- Sequencer for one inference pass of the 121-input, 10-class fully connected classifier.
- Accepts a binarised 11x11 image over a valid/ready handshake and drives it, held stable, into the input feature register.
- Steps the output-neuron datapath through every class index, samples each class score and tracks the running argmax.
- Returns the winning digit and its score over a second valid/ready handshake.

Parameters:
- IMAGE_SIZE, 121: image bits (11*11); width of img_data and feat_out.
- NUM_CLASSES, 10: number of output neurons scanned per inference.
- SCORE_W, 16: width of the signed two's-complement class score.
- NEURON_LAT, 2: cycles neuron_sel is held per class; score_in is valid on the last of these cycles. Legal range is 1 or more.
- IDX_W, 4: width of the class index; must satisfy 2**IDX_W >= NUM_CLASSES.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- img_vld, in, 1: image offered.
- img_rdy, out, 1: controller can accept an image.
- img_data, in, IMAGE_SIZE: image bits.
- feat_out, out, IMAGE_SIZE: captured image, drives the input feature register.
- neuron_en, out, 1: datapath evaluate enable.
- neuron_sel, out, IDX_W: class index under evaluation.
- score_in, in, SCORE_W: signed score from the datapath.
- busy, out, 1: inference in progress.
- res_vld, out, 1: result valid.
- res_rdy, in, 1: result consumed.
- res_digit, out, IDX_W: argmax class.
- res_score, out, SCORE_W: score of the argmax class.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: feat_out, neuron_sel, neuron_en, busy, res_vld, res_digit, res_score.
  - Exception: img_rdy goes to 1 on the first clock after reset deasserts. It is held 0 while reset is asserted.
  - Internal counters clear.
- Reset mid-operation aborts the pass. No partial result is ever presented.
- States: IDLE, LOAD, COMPUTE, DONE. All outputs are registered.
- IDLE:
  - img_rdy=1, busy=0.
  - On img_vld & img_rdy at an edge: feat_out <= img_data, go to LOAD.
  - img_rdy falls in the same edge.
- LOAD:
  - Lasts exactly 1 cycle, giving the downstream 1-cycle input register time to latch feat_out.
  - busy=1.
  - Then go to COMPUTE with neuron_sel=0, phase counter=0.
- COMPUTE:
  - busy=1, neuron_en=1.
  - neuron_sel is held for NEURON_LAT cycles per class.
  - On the final cycle of each window (phase == NEURON_LAT-1), score_in is sampled:
    - Index 0 unconditionally initialises best_score/best_idx.
    - Later indices replace the best only if score_in > best_score (signed, strictly greater). Ties keep the lower index.
  - After sampling index NUM_CLASSES-1, go to DONE. Otherwise neuron_sel increments and phase resets.
  - neuron_sel never exceeds NUM_CLASSES-1.
- DONE:
  - neuron_en=0, busy=1, res_vld=1.
  - res_digit/res_score = best_idx/best_score, held stable until the handshake.
  - On res_vld & res_rdy: res_vld <= 0, go to IDLE, img_rdy <= 1.
  - res_digit/res_score keep their last values until the next DONE.
- Throughout LOAD, COMPUTE and DONE:
  - feat_out is held constant.
  - img_vld is ignored; no capture occurs.
- Latency:
  - Accept edge E0.
  - res_vld rises after edge E0 + 1 + NUM_CLASSES*NEURON_LAT, i.e. 21 cycles for the defaults.
  - Minimum image-to-image period is that latency + 2 cycles with res_rdy tied high.

Optional Feature:
- Macro: FCNN_INFER_PERF_CNT_EN.
- When defined:
  - Adds output port infer_cycles (16 bits).
  - A counter clears on the accept edge and increments every cycle while busy and res_vld=0.
  - Its final value is latched into infer_cycles when res_vld rises and held until the next result.
  - infer_cycles resets to 0 and saturates at 16'hFFFF.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle:
  - Stimulus: assert reset=0 mid-COMPUTE (neuron_sel=5); release, then offer a new image.
  - Required: all outputs clear immediately, no res_vld is produced, img_rdy=1 on the first clock after release, and the new image is accepted normally.
- Nominal argmax:
  - Stimulus: scores by index {3,-2,7,100,5,0,-50,99,100,12}.
  - Required: res_digit=3, res_score=100. The tie at index 8 keeps index 3. res_vld rises 21 cycles after accept.
- All negative:
  - Stimulus: scores {-10,-3,-3,-8,...,-9}.
  - Required: res_digit=1, res_score=-3 (16'hFFFD). Confirms signed compare and tie-to-lower.
- Backpressure:
  - Stimulus: hold res_rdy=0 for 15 cycles in DONE, and pulse img_vld during this time.
  - Required: res_vld, res_digit and res_score stable; img_rdy=0; feat_out unchanged. Release gives a 1-cycle handshake, then IDLE.
- Sequencing:
  - Stimulus: monitor neuron_sel/neuron_en during COMPUTE.
  - Required: indices 0..9 each held exactly 2 cycles; neuron_en=1 only in COMPUTE; feat_out equals the captured image for the whole pass.
- Perf counter (FCNN_INFER_PERF_CNT_EN defined):
  - Stimulus: run the nominal pass.
  - Required: infer_cycles=21, and it is held through the next accept until the next result.
